// File: rtl/hdp_timing_pkg.sv
// Shared timing constants and FSM state encoding for the HDP line streamer.
package hdp_timing_pkg;

    localparam int LCD_WIDTH          = 32;
    localparam int DEF_WORDS_PER_LINE = 40;
    localparam int DEF_BLANK_WORDS    = 4;
    localparam int DEF_LINES          = 1280;
    localparam int DEF_BACK_PORCH     = 24;
    localparam int DEF_UPDATE_WORDS   = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2,
        PORCH  = 2'd3
    } hdpState_t;

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdp_pattern_gen.sv
// Test-pattern source for the line streamer, built only with HDP_TEST_PATTERN_EN.
// Latches the pattern select at frame start and forms {line, word} coded words.
module hdp_pattern_gen
    import hdp_timing_pkg::*;
#(
    parameter int DATA_WIDTH = LCD_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_sample,
    input  logic                  i_patternSel,
    input  logic [10:0]           i_lineCount,
    input  logic [15:0]           i_wordIndex,
    output logic                  o_patternOn,
    output logic [DATA_WIDTH-1:0] o_patternWord
);

    logic        patSel;
    logic [31:0] rawWord;

    // Hold the select for the whole frame so a mid-frame toggle cannot tear it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            patSel <= 1'b0;
        end else if (i_sample) begin
            patSel <= i_patternSel;
        end
    end

    assign rawWord       = {5'b0, i_lineCount, i_wordIndex};
    assign o_patternWord = DATA_WIDTH'(rawWord);
    assign o_patternOn   = patSel;

endmodule

// File: rtl/hdp_line_streamer.sv
// HDP panel line streamer: pops the FWFT pixel FIFO once per active word and
// generates line/frame timing (active, blank, back porch).
// Optional build macro: HDP_TEST_PATTERN_EN adds i_patternSel and a pattern source.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_enable and FIFO data before the first frame
// ACTIVE | one word per cycle onto the bus, WORDS_PER_LINE cycles
// BLANK  | zero words, o_valid low, BLANK_WORDS cycles at line end
// PORCH  | zero words, o_valid low, BACK_PORCH cycles after last line
module hdp_line_streamer
    import hdp_timing_pkg::*;
#(
    parameter int DATA_WIDTH     = LCD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int BLANK_WORDS    = DEF_BLANK_WORDS,
    parameter int LINES          = DEF_LINES,
    parameter int BACK_PORCH     = DEF_BACK_PORCH,
    parameter int UPDATE_WORDS   = DEF_UPDATE_WORDS
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_fifoData,
    input  logic                  i_fifoEmpty,
`ifdef HDP_TEST_PATTERN_EN
    input  logic                  i_patternSel,
`endif
    output logic                  o_fifoRead,
    output logic [DATA_WIDTH-1:0] o_lcdData,
    output logic                  o_valid,
    output logic                  o_update,
    output logic                  o_frameStart,
    output logic [10:0]           o_lineCount,
    output logic [15:0]           o_underflowCount,
    output logic                  o_busy
);

    localparam int WW = cntWidth(WORDS_PER_LINE);
    localparam int BW = cntWidth(BLANK_WORDS);
    localparam int LW = cntWidth(LINES);
    localparam int PW = cntWidth(BACK_PORCH);
    localparam int UW = cntWidth(UPDATE_WORDS + 1);

    hdpState_t             state;
    hdpState_t             stateNext;
    logic [WW-1:0]         wordCnt;
    logic [BW-1:0]         blankCnt;
    logic [LW-1:0]         lineCnt;
    logic [PW-1:0]         porchCnt;
    logic [UW-1:0]         updCnt;
    logic [15:0]           underflowCnt;
    logic [DATA_WIDTH-1:0] lcdData;
    logic                  valid;
    logic                  update;
    logic                  frameStart;

    logic                  wordLast;
    logic                  blankLast;
    logic                  lineLast;
    logic                  porchLast;
    logic                  frameBegin;
    logic                  fifoRead;
    logic                  underflowHit;
    logic [DATA_WIDTH-1:0] dataNext;
    logic                  validNext;
    logic                  updateNext;
    logic                  frameStartNext;
    logic                  patternOn;
    logic                  patternStart;
    logic [DATA_WIDTH-1:0] patternWord;

    assign wordLast   = (wordCnt  == WW'(WORDS_PER_LINE - 1));
    assign blankLast  = (blankCnt == BW'(BLANK_WORDS - 1));
    assign lineLast   = (lineCnt  == LW'(LINES - 1));
    assign porchLast  = (porchCnt == PW'(BACK_PORCH - 1));
    assign frameBegin = (stateNext == ACTIVE) && ((state == IDLE) || (state == PORCH));

`ifdef HDP_TEST_PATTERN_EN
    assign patternStart = i_patternSel;

    hdp_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_patternGen (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_sample      (frameBegin),
        .i_patternSel  (i_patternSel),
        .i_lineCount   (o_lineCount),
        .i_wordIndex   (16'(wordCnt)),
        .o_patternOn   (patternOn),
        .o_patternWord (patternWord)
    );
`else
    assign patternStart = 1'b0;
    assign patternOn    = 1'b0;
    assign patternWord  = '0;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, pop decision and next values of the registered bus outputs.
    always_comb begin
        stateNext      = state;
        fifoRead       = 1'b0;
        underflowHit   = 1'b0;
        dataNext       = '0;
        validNext      = 1'b0;
        frameStartNext = 1'b0;
        updateNext     = 1'b0;
        case (state)
            IDLE: begin
                // A pattern frame needs no FIFO data to get going.
                if (i_enable && (!i_fifoEmpty || patternStart)) begin
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                validNext      = 1'b1;
                frameStartNext = (lineCnt == '0) && (wordCnt == '0);
                if (patternOn) begin
                    dataNext = patternWord;
                end else if (!i_fifoEmpty) begin
                    fifoRead = 1'b1;
                    dataNext = i_fifoData;
                end else begin
                    underflowHit = 1'b1;
                end
                if (wordLast) begin
                    stateNext = BLANK;
                end
            end
            BLANK: begin
                if (blankLast) begin
                    stateNext = lineLast ? PORCH : ACTIVE;
                end
            end
            PORCH: begin
                // Back-to-back frames restart without waiting on the FIFO.
                if (porchLast) begin
                    stateNext = i_enable ? ACTIVE : IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        updateNext = ((state == ACTIVE) || (state == BLANK)) && (updCnt < UW'(UPDATE_WORDS));
    end

    // Word, blank, line, porch and update-window counters.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wordCnt  <= '0;
            blankCnt <= '0;
            lineCnt  <= '0;
            porchCnt <= '0;
            updCnt   <= '0;
        end else begin
            case (state)
                ACTIVE: begin
                    wordCnt <= wordLast ? '0 : wordCnt + 1'b1;
                end
                BLANK: begin
                    blankCnt <= blankLast ? '0 : blankCnt + 1'b1;
                    if (blankLast && !lineLast) begin
                        lineCnt <= lineCnt + 1'b1;
                    end
                end
                PORCH: begin
                    porchCnt <= porchLast ? '0 : porchCnt + 1'b1;
                    if (porchLast) begin
                        lineCnt <= '0;
                    end
                end
                default: begin
                end
            endcase
            // Counts frame cycles from line 0 word 0; cleared outside a frame body.
            if ((state == ACTIVE) || (state == BLANK)) begin
                if (updCnt < UW'(UPDATE_WORDS)) begin
                    updCnt <= updCnt + 1'b1;
                end
            end else begin
                updCnt <= '0;
            end
        end
    end

    // Registered panel bus, one cycle behind the pop decision.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lcdData    <= '0;
            valid      <= 1'b0;
            update     <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            lcdData    <= dataNext;
            valid      <= validNext;
            update     <= updateNext;
            frameStart <= frameStartNext;
        end
    end

    // Saturating count of active words sent without FIFO data.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            underflowCnt <= '0;
        end else if (underflowHit && (underflowCnt != 16'hFFFF)) begin
            underflowCnt <= underflowCnt + 16'd1;
        end
    end

    // Pop is suppressed during reset so the FIFO is not drained by a dying frame.
    assign o_fifoRead       = fifoRead && !i_reset;
    assign o_lcdData        = lcdData;
    assign o_valid          = valid;
    assign o_update         = update;
    assign o_frameStart     = frameStart;
    assign o_lineCount      = 11'(lineCnt);
    assign o_underflowCount = underflowCnt;
    assign o_busy           = (state != IDLE);

endmodule
